// File: rtl/glyph_scan_rom_if.sv
// glyph_scan_rom_if: control and pin bundle of the glyph scanner.
//   master : en, load, glyph_sel driven by the control side; observes the rest
//   slave  : the scanner itself; drives col_n, row_n, cur_glyph,
//            frame_done, load_err
interface glyph_scan_rom_if #(
  parameter int COLS = 5,
  parameter int ROWS = 7,
  parameter int GW   = 2
);
  logic            en;
  logic            load;
  logic [GW-1:0]   glyph_sel;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [GW-1:0]   cur_glyph;
  logic            frame_done;
  logic            load_err;

  modport master (
    output en, load, glyph_sel,
    input  col_n, row_n, cur_glyph, frame_done, load_err
  );

  modport slave (
    input  en, load, glyph_sel,
    output col_n, row_n, cur_glyph, frame_done, load_err
  );
endinterface

// File: rtl/glyph_scan_rom.sv
// glyph_scan_rom: multi-glyph 5x7 pattern table with an autonomous column
// scanner driving active-low matrix pins. Glyph changes requested while
// scanning are held pending and committed only at the frame wrap.
//   clk, rst_n      : system clock, async active-low reset
//   bus.en          : scan enable, 0 blanks the display
//   bus.load        : one-cycle glyph change request with bus.glyph_sel
//   bus.col_n/row_n : active-low column select / row data
//   bus.cur_glyph   : glyph being displayed
//   bus.frame_done  : pulse after the last column step
//   bus.load_err    : pulse after a load with an out-of-range index
//
// state   | meaning
// ST_IDLE | display blanked, prescaler and column held at 0
// ST_SCAN | scanning columns, one step every DIV clocks
module glyph_scan_rom #(
  parameter int COLS   = 5,
  parameter int ROWS   = 7,
  parameter int GLYPHS = 4,
  parameter int DIV    = 4,
  parameter int GW     = 2
) (
  input logic             clk,
  input logic             rst_n,
  glyph_scan_rom_if.slave bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = $clog2(DIV);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [CW-1:0] col_idx, col_d;
  logic [GW-1:0] cur_glyph, cur_d;
  logic [GW-1:0] pend_glyph, pend_d;
  logic          pend_valid, pv_d;
  logic          frame_done, fd_d;
  logic          load_err, le_d;
  logic          sel_bad;

  function automatic logic [6:0] pattern(input logic [GW-1:0] g,
                                         input logic [CW-1:0] c);
    logic [6:0] p;
    p = 7'b1111111;
    if (int'(g) == 0) begin
      case (int'(c))
        0, 4:    p = 7'b1100000;
        1, 3:    p = 7'b1011011;
        2:       p = 7'b0111011;
        default: p = 7'b1111111;
      endcase
    end else if (int'(g) == 2) begin
      p = 7'b0000000;
    end else if (int'(g) == 3) begin
      p = c[0] ? 7'b1010101 : 7'b0101010;
    end
    return p;
  endfunction

  assign sel_bad = (32'(bus.glyph_sel) >= 32'(GLYPHS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      presc      <= '0;
      col_idx    <= '0;
      cur_glyph  <= '0;
      pend_glyph <= '0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_d;
      presc      <= presc_d;
      col_idx    <= col_d;
      cur_glyph  <= cur_d;
      pend_glyph <= pend_d;
      pend_valid <= pv_d;
      frame_done <= fd_d;
      load_err   <= le_d;
    end
  end

  always_comb begin
    state_d = bus.en ? ST_SCAN : ST_IDLE;
    presc_d = presc;
    col_d   = col_idx;
    cur_d   = cur_glyph;
    pend_d  = pend_glyph;
    pv_d    = pend_valid;
    fd_d    = 1'b0;
    le_d    = 1'b0;

    if (!bus.en) begin
      presc_d = '0;
      col_d   = '0;
    end else if (state == ST_SCAN) begin
      if (presc == PW'(DIV - 1)) begin
        presc_d = '0;
        if (col_idx == CW'(COLS - 1)) begin
          col_d = '0;
          fd_d  = 1'b1;
          if (pend_valid) begin
            cur_d = pend_glyph;
            pv_d  = 1'b0;
          end
        end else begin
          col_d = col_idx + CW'(1);
        end
      end else begin
        presc_d = presc + PW'(1);
      end
    end

    // Load is judged against the post-edge scan state; a load on the wrap
    // edge lands after the commit above, so it becomes the next pending.
    if (bus.load) begin
      if (sel_bad) begin
        le_d = 1'b1;
      end else if (state_d == ST_IDLE) begin
        cur_d = bus.glyph_sel;
        pv_d  = 1'b0;
      end else begin
        pend_d = bus.glyph_sel;
        pv_d   = 1'b1;
      end
    end
  end

  assign bus.col_n      = (state == ST_SCAN) ? ~(COLS'(1) << col_idx) : '1;
  assign bus.row_n      = (state == ST_SCAN) ? ROWS'(pattern(cur_glyph, col_idx)) : '1;
  assign bus.cur_glyph  = cur_glyph;
  assign bus.frame_done = frame_done;
  assign bus.load_err   = load_err;
endmodule

// File: tb/tb_glyph_scan_rom.sv
module tb_glyph_scan_rom;
  localparam int COLS = 5, ROWS = 7, GLYPHS = 4, DIV = 4, GW = 3;
  localparam int FR = COLS * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fd = -1;

  glyph_scan_rom_if #(.COLS(COLS), .ROWS(ROWS), .GW(GW)) bus ();

  glyph_scan_rom #(.COLS(COLS), .ROWS(ROWS), .GLYPHS(GLYPHS), .DIV(DIV), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: time since scan start, current glyph, pending queue.
  logic [6:0] tbl [4][5] = '{
    '{7'b1100000, 7'b1011011, 7'b0111011, 7'b1011011, 7'b1100000},
    '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111},
    '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000},
    '{7'b0101010, 7'b1010101, 7'b0101010, 7'b1010101, 7'b0101010}};
  bit   m_on = 0;
  int   m_t = 0;
  int   m_cur = 0;
  int   m_pend[$];
  bit   m_fd = 0;
  bit   m_le = 0;

  function automatic int m_col();
    return (m_t / DIV) % COLS;
  endfunction

  function automatic bit wrap_next();
    return m_on && (m_t % FR == FR - 1);
  endfunction

  task automatic model_reset();
    m_on = 0; m_t = 0; m_cur = 0; m_pend.delete(); m_fd = 0; m_le = 0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int s);
    bit wrap;
    wrap = m_on && e && (m_t % FR == FR - 1);
    if (!e) m_t = 0;
    else if (m_on) m_t = (m_t + 1) % FR;
    m_fd = wrap;
    m_le = 0;
    if (wrap && m_pend.size() > 0) m_cur = m_pend.pop_front();
    if (l) begin
      if (s >= GLYPHS) m_le = 1;
      else if (!e) begin m_cur = s; m_pend.delete(); end
      else begin m_pend.delete(); m_pend.push_back(s); end
    end
    m_on = e;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [4:0] one;
    logic [4:0] ecol;
    logic [6:0] erow;
    one  = 5'b00001;
    ecol = m_on ? ~(one << m_col()) : 5'b11111;
    erow = m_on ? tbl[m_cur][m_col()] : 7'b1111111;
    chk("col_n", 32'(bus.col_n), 32'(ecol));
    chk("row_n", 32'(bus.row_n), 32'(erow));
    chk("cur_glyph", 32'(bus.cur_glyph), 32'(m_cur));
    chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
    chk("load_err", 32'(bus.load_err), 32'(m_le));
  endtask

  task automatic step(input bit e, input bit l, input int s);
    bus.en = e;
    bus.load = l;
    bus.glyph_sel = GW'(s);
    @(posedge clk);
    model_edge(e, l, s);
    cyc++;
    #1;
    check_model();
    if (!e) last_fd = -1;
    else if (bus.frame_done === 1'b1) begin
      if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(FR));
      last_fd = cyc;
    end
    bus.load = 1'b0;
  endtask

  task automatic run_until_col(input int c);
    for (int i = 0; i < 2 * FR && !(m_on && m_col() == c && m_t % DIV == 0); i++) step(1, 0, 0);
    chk("reach_col", 32'(m_col()), 32'(c));
  endtask

  task automatic run_to_wrap(input bit l, input int s);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      if (wrap_next()) begin
        step(1, l, s);
        seen = 1;
      end else step(1, 0, 0);
    end
    chk("wrap_seen", 32'(bus.frame_done), 32'(1));
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.glyph_sel = '0;
    model_reset();
    #12;
    chk("rst_col_n", 32'(bus.col_n), 32'h1F);
    chk("rst_row_n", 32'(bus.row_n), 32'h7F);
    chk("rst_fd", 32'(bus.frame_done), 32'(0));
    chk("rst_le", 32'(bus.load_err), 32'(0));
    chk("rst_cur", 32'(bus.cur_glyph), 32'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // Enable: column 0 after one edge, column 1 after DIV more.
    step(1, 0, 0);
    chk("en_col0", 32'(bus.col_n), 32'(5'b11110));
    chk("en_row0", 32'(bus.row_n), 32'(7'b1100000));
    for (int i = 0; i < DIV - 1; i++) step(1, 0, 0);
    chk("still_col0", 32'(bus.col_n), 32'(5'b11110));
    step(1, 0, 0);
    chk("en_col1", 32'(bus.col_n), 32'(5'b11101));
    chk("en_row1", 32'(bus.row_n), 32'(7'b1011011));
    for (int i = 0; i < 2 * FR; i++) step(1, 0, 0);

    // Mid-frame load of glyph 2 waits for the wrap.
    run_until_col(2);
    step(1, 1, 2);
    chk("pend_cur", 32'(bus.cur_glyph), 32'(0));
    run_to_wrap(0, 0);
    chk("wrap_cur2", 32'(bus.cur_glyph), 32'(2));
    chk("wrap_row2", 32'(bus.row_n), 32'(7'b0000000));

    // Two loads in one frame: last one wins.
    run_until_col(1);
    step(1, 1, 1);
    run_until_col(3);
    step(1, 1, 3);
    run_to_wrap(0, 0);
    chk("last_wins", 32'(bus.cur_glyph), 32'(3));
    for (int i = 0; i < DIV; i++) step(1, 0, 0);
    chk("g3_col1_row", 32'(bus.row_n), 32'(7'b1010101));

    // Disable mid-frame, load while idle, restart at column 0.
    run_until_col(3);
    step(0, 0, 0);
    chk("dis_col_n", 32'(bus.col_n), 32'h1F);
    chk("dis_row_n", 32'(bus.row_n), 32'h7F);
    step(0, 1, 1);
    chk("idle_load", 32'(bus.cur_glyph), 32'(1));
    step(0, 0, 0);
    step(1, 0, 0);
    chk("restart_col", 32'(bus.col_n), 32'(5'b11110));
    chk("restart_row", 32'(bus.row_n), 32'(7'b1111111));

    // Pending glyph 0, then load 3 on the wrap edge: 0 now, 3 next frame.
    run_until_col(1);
    step(1, 1, 0);
    run_to_wrap(1, 3);
    chk("coinc_commit", 32'(bus.cur_glyph), 32'(0));
    run_to_wrap(0, 0);
    chk("coinc_next", 32'(bus.cur_glyph), 32'(3));

    // Out-of-range index, then async reset mid-column.
    run_until_col(2);
    step(1, 1, 5);
    chk("bad_le", 32'(bus.load_err), 32'(1));
    chk("bad_cur", 32'(bus.cur_glyph), 32'(3));
    step(1, 0, 0);
    chk("bad_le_clr", 32'(bus.load_err), 32'(0));
    #3; rst_n = 1'b0; #1;
    model_reset();
    chk("arst_col_n", 32'(bus.col_n), 32'h1F);
    chk("arst_row_n", 32'(bus.row_n), 32'h7F);
    chk("arst_cur", 32'(bus.cur_glyph), 32'(0));
    bus.en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last_fd = -1;
    check_model();

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      bit e, l;
      e = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 9) == 0);
      step(e, l, int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
